// File: rtl/mario_obj_dma_pkg.sv
// Shared types and defaults for the sprite DMA engine that copies work RAM
// into object RAM over the Z80 bus.
package mario_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_HOLD, S_REL
  } dma_state_e;

  localparam logic [15:0] MARIO_SRC_BASE = 16'h6900;
  localparam logic [15:0] MARIO_DST_BASE = 16'h7000;
  localparam int          MARIO_LEN      = 384;

  // DMA RDY lives at bit 5 of the misc control latch at 7E85H
  localparam int          MARIO_RDY_BIT  = 5;

  localparam int          CNT_W          = 10;

  // 16-bit address sum, wraps silently past FFFFH
  function automatic logic [15:0] dma_addr(input logic [15:0] base,
                                           input logic [CNT_W-1:0] cnt);
    return base + {6'd0, cnt};
  endfunction

endpackage

// File: rtl/mario_obj_dma_if.sv
// CPU-side bus as seen by the DMA engine: master = DMA, slave = bus/RAM side.
interface mario_obj_dma_if;
  logic        O_BUSRQ_n;
  logic        I_BUSAK_n;
  logic        O_BUS_EN;
  logic [15:0] O_AB;
  logic [7:0]  O_DB;
  logic [7:0]  I_DB;
  logic        O_MREQ_n;
  logic        O_RD_n;
  logic        O_WR_n;

  modport master (
    output O_BUSRQ_n, O_BUS_EN, O_AB, O_DB, O_MREQ_n, O_RD_n, O_WR_n,
    input  I_BUSAK_n, I_DB
  );

  modport slave (
    input  O_BUSRQ_n, O_BUS_EN, O_AB, O_DB, O_MREQ_n, O_RD_n, O_WR_n,
    output I_BUSAK_n, I_DB
  );
endinterface

// File: rtl/mario_obj_dma.sv
// Sprite DMA: on a rising DMA RDY edge, grab the Z80 bus and copy LEN bytes
// from SRC_BASE to DST_BASE at 4 clocks per byte, then release the bus.
module mario_obj_dma
  import mario_pkg::*;
#(
  parameter logic [15:0] SRC_BASE = MARIO_SRC_BASE,
  parameter logic [15:0] DST_BASE = MARIO_DST_BASE,
  parameter int          LEN      = MARIO_LEN
) (
  input  logic            I_CLK,
  input  logic            I_RESET_n,
  input  logic            I_RDY,
  mario_obj_dma_if.master bus,
  output logic            O_BUSY,
  output logic            O_DONE
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  dma_state_e       r_state;
  logic             r_rdy, r_rdy_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busrq_n, r_bus_en, r_mreq_n, r_rd_n, r_wr_n;
  logic [15:0]      r_ab;
  logic [7:0]       r_db;
  logic             r_busy, r_done;

  logic             w_trig;
  logic [15:0]      w_src, w_src_nx, w_dst;

  assign w_trig   = r_rdy & ~r_rdy_d;
  assign w_src    = dma_addr(SRC_BASE, r_cnt);
  assign w_src_nx = dma_addr(SRC_BASE, r_cnt + 1'b1);
  assign w_dst    = dma_addr(DST_BASE, r_cnt);

  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      r_state   <= S_IDLE;
      r_rdy     <= 1'b0;
      r_rdy_d   <= 1'b0;
      r_cnt     <= '0;
      r_busrq_n <= 1'b1;
      r_bus_en  <= 1'b0;
      r_ab      <= '0;
      r_db      <= '0;
      r_mreq_n  <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rdy   <= I_RDY;
      r_rdy_d <= r_rdy;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_trig) begin
          r_state   <= S_REQ;
          r_busy    <= 1'b1;
          r_busrq_n <= 1'b0;
          r_cnt     <= '0;
        end
        // REQ and HOLD both (re)start the current byte from its read
        S_REQ, S_HOLD: if (!bus.I_BUSAK_n) begin
          r_state  <= S_RD_A;
          r_bus_en <= 1'b1;
          r_ab     <= w_src;
          r_mreq_n <= 1'b0;
          r_rd_n   <= 1'b0;
        end
        S_RD_A, S_RD_B, S_WR_A, S_WR_B: begin
          if (bus.I_BUSAK_n) begin
            // bus stolen: float everything, keep requesting, redo this byte
            r_state  <= S_HOLD;
            r_bus_en <= 1'b0;
            r_mreq_n <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
          end else begin
            unique case (r_state)
              S_RD_A: r_state <= S_RD_B;
              S_RD_B: begin
                r_state <= S_WR_A;
                r_db    <= bus.I_DB;
                r_ab    <= w_dst;
                r_rd_n  <= 1'b1;
              end
              S_WR_A: begin
                r_state <= S_WR_B;
                r_wr_n  <= 1'b0;
              end
              default: begin
                r_wr_n <= 1'b1;
                r_cnt  <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                  r_state   <= S_REL;
                  r_busrq_n <= 1'b1;
                  r_bus_en  <= 1'b0;
                  r_mreq_n  <= 1'b1;
                end else begin
                  r_state <= S_RD_A;
                  r_ab    <= w_src_nx;
                  r_rd_n  <= 1'b0;
                end
              end
            endcase
          end
        end
        S_REL: if (bus.I_BUSAK_n) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.O_BUSRQ_n = r_busrq_n;
  assign bus.O_BUS_EN  = r_bus_en;
  assign bus.O_AB      = r_ab;
  assign bus.O_DB      = r_db;
  assign bus.O_MREQ_n  = r_mreq_n;
  assign bus.O_RD_n    = r_rd_n;
  assign bus.O_WR_n    = r_wr_n;
  assign O_BUSY        = r_busy;
  assign O_DONE        = r_done;

endmodule
